// File: rtl/retire_trace_unit.sv
// Retirement monitor beside the writeback stage: classifies each retired instruction,
// queues a trace record in a small FIFO, and tracks cycle/inst/drop counters, halt and a hang watchdog.
module retire_trace_unit #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int REG_W      = 4,
    parameter int CNT_W      = 32,
    parameter int DEPTH      = 8,
    parameter int WDOG_LIMIT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ret_valid,
    input  logic [ADDR_W-1:0] ret_pc,
    input  logic              ret_regwrite,
    input  logic [REG_W-1:0]  ret_wreg,
    input  logic [DATA_W-1:0] ret_wdata,
    input  logic              ret_memread,
    input  logic              ret_memwrite,
    input  logic [ADDR_W-1:0] ret_memaddr,
    input  logic [DATA_W-1:0] ret_memdata,
    input  logic              ret_halt,
    output logic              trc_valid,
    input  logic              trc_ready,
    output logic [1:0]        trc_kind,
    output logic              trc_load,
    output logic [CNT_W-1:0]  trc_inum,
    output logic [ADDR_W-1:0] trc_pc,
    output logic [REG_W-1:0]  trc_reg,
    output logic [DATA_W-1:0] trc_value,
    output logic [ADDR_W-1:0] trc_addr,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  inst_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              halted,
    output logic              done,
    output logic              timeout
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WD_W  = $clog2(WDOG_LIMIT + 1);
    localparam logic [PTR_W:0]  CNT_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_LIMIT = (PTR_W+1)'(DEPTH - 1);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WDOG_LIMIT - 1);

    localparam logic [1:0] KIND_OTHER = 2'b00;
    localparam logic [1:0] KIND_REG   = 2'b01;
    localparam logic [1:0] KIND_STORE = 2'b10;
    localparam logic [1:0] KIND_HALT  = 2'b11;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_TIMEOUT} state_t;

    state_t state, state_nxt;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [WD_W-1:0]  wdog;

    logic [1:0]        mem_kind  [DEPTH];
    logic              mem_load  [DEPTH];
    logic [CNT_W-1:0]  mem_inum  [DEPTH];
    logic [ADDR_W-1:0] mem_pc    [DEPTH];
    logic [REG_W-1:0]  mem_reg   [DEPTH];
    logic [DATA_W-1:0] mem_value [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];

    logic              accept, push, pop, drop, expire;
    logic [1:0]        rec_kind;
    logic [REG_W-1:0]  rec_reg;
    logic [DATA_W-1:0] rec_value;
    logic [ADDR_W-1:0] rec_addr;

    assign accept = (state == S_RUN) && ret_valid;
    // Last slot is reserved for the halt record; occupancy is the pre-pop count.
    assign push   = accept && (ret_halt ? (count != CNT_FULL) : (count < CNT_LIMIT));
    assign drop   = accept && !push;
    assign pop    = trc_valid && trc_ready;
    assign expire = (state == S_RUN) && !ret_valid && (wdog == WD_LAST);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rec_kind  = KIND_OTHER;
        rec_reg   = '0;
        rec_value = '0;
        if (ret_halt) begin
            rec_kind = KIND_HALT;
        end else if (ret_regwrite) begin
            rec_kind  = KIND_REG;
            rec_reg   = ret_wreg;
            rec_value = ret_wdata;
        end else if (ret_memwrite) begin
            rec_kind  = KIND_STORE;
            rec_value = ret_memdata;
        end
        rec_addr = (ret_memread || ret_memwrite) ? ret_memaddr : '0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RUN: begin
                if (accept && ret_halt) state_nxt = S_DRAIN;
                else if (expire)        state_nxt = S_TIMEOUT;
            end
            S_DRAIN:   if (pop && trc_kind == KIND_HALT) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_DONE;
            S_TIMEOUT: state_nxt = S_TIMEOUT;
            default:   state_nxt = S_RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wdog      <= '0;
            cycle_cnt <= '0;
            inst_cnt  <= '0;
            drop_cnt  <= '0;
            halted    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
            if (state == S_RUN) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                if (ret_valid)      wdog <= '0;
                else if (!expire)   wdog <= wdog + WD_W'(1);
            end
            if (accept) inst_cnt <= inst_cnt + CNT_W'(1);
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            if (accept && ret_halt) halted <= 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_kind[wr_ptr]  <= rec_kind;
            mem_load[wr_ptr]  <= ret_memread && ret_regwrite;
            mem_inum[wr_ptr]  <= inst_cnt;
            mem_pc[wr_ptr]    <= ret_pc;
            mem_reg[wr_ptr]   <= rec_reg;
            mem_value[wr_ptr] <= rec_value;
            mem_addr[wr_ptr]  <= rec_addr;
        end
    end

    assign trc_valid = (count != '0);
    assign trc_kind  = mem_kind[rd_ptr];
    assign trc_load  = mem_load[rd_ptr];
    assign trc_inum  = mem_inum[rd_ptr];
    assign trc_pc    = mem_pc[rd_ptr];
    assign trc_reg   = mem_reg[rd_ptr];
    assign trc_value = mem_value[rd_ptr];
    assign trc_addr  = mem_addr[rd_ptr];
    assign done      = (state == S_DONE);
    assign timeout   = (state == S_TIMEOUT);

endmodule

// File: tb/tb_retire_trace_unit.sv
// Directed bench for retire_trace_unit with DEPTH=4, WDOG_LIMIT=16; inputs change and
// outputs are observed on the falling edge.
module tb_retire_trace_unit;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int REG_W  = 4;
    localparam int CNT_W  = 32;

    logic              clk;
    logic              rst_n;
    logic              ret_valid;
    logic [ADDR_W-1:0] ret_pc;
    logic              ret_regwrite;
    logic [REG_W-1:0]  ret_wreg;
    logic [DATA_W-1:0] ret_wdata;
    logic              ret_memread;
    logic              ret_memwrite;
    logic [ADDR_W-1:0] ret_memaddr;
    logic [DATA_W-1:0] ret_memdata;
    logic              ret_halt;
    logic              trc_valid;
    logic              trc_ready;
    logic [1:0]        trc_kind;
    logic              trc_load;
    logic [CNT_W-1:0]  trc_inum;
    logic [ADDR_W-1:0] trc_pc;
    logic [REG_W-1:0]  trc_reg;
    logic [DATA_W-1:0] trc_value;
    logic [ADDR_W-1:0] trc_addr;
    logic [CNT_W-1:0]  cycle_cnt;
    logic [CNT_W-1:0]  inst_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              halted;
    logic              done;
    logic              timeout;

    int n_checks = 0;
    int n_errors = 0;

    retire_trace_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W), .CNT_W(CNT_W),
        .DEPTH(4), .WDOG_LIMIT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ret_valid(ret_valid), .ret_pc(ret_pc), .ret_regwrite(ret_regwrite),
        .ret_wreg(ret_wreg), .ret_wdata(ret_wdata), .ret_memread(ret_memread),
        .ret_memwrite(ret_memwrite), .ret_memaddr(ret_memaddr), .ret_memdata(ret_memdata),
        .ret_halt(ret_halt),
        .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_kind(trc_kind),
        .trc_load(trc_load), .trc_inum(trc_inum), .trc_pc(trc_pc), .trc_reg(trc_reg),
        .trc_value(trc_value), .trc_addr(trc_addr),
        .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .drop_cnt(drop_cnt),
        .halted(halted), .done(done), .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        ret_valid    = 1'b0;
        ret_pc       = '0;
        ret_regwrite = 1'b0;
        ret_wreg     = '0;
        ret_wdata    = '0;
        ret_memread  = 1'b0;
        ret_memwrite = 1'b0;
        ret_memaddr  = '0;
        ret_memdata  = '0;
        ret_halt     = 1'b0;
    endtask

    task automatic retire(input logic [15:0] pc, input logic rw, input logic [3:0] wreg,
                          input logic [15:0] wdata, input logic mr, input logic mw,
                          input logic [15:0] maddr, input logic [15:0] mdata, input logic hlt);
        ret_valid    = 1'b1;
        ret_pc       = pc;
        ret_regwrite = rw;
        ret_wreg     = wreg;
        ret_wdata    = wdata;
        ret_memread  = mr;
        ret_memwrite = mw;
        ret_memaddr  = maddr;
        ret_memdata  = mdata;
        ret_halt     = hlt;
    endtask

    // Leaves reset released at a falling edge so the next rising edge is the first RUN cycle.
    task automatic do_reset();
        rst_n     = 1'b0;
        trc_ready = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        trc_ready = 1'b0;
        idle();

        // Asynchronous reset in the middle of a run with three records queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            retire(16'h0100 + 16'(i), 1'b1, 4'd1, 16'h0011, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            tick();
        end
        idle();
        check("pre_reset_valid", 64'(trc_valid), 64'd1);
        check("pre_reset_inst", 64'(inst_cnt), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(trc_valid), 64'd0);
        check("rst_cycle", 64'(cycle_cnt), 64'd0);
        check("rst_inst", 64'(inst_cnt), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_flags", {61'd0, halted, done, timeout}, 64'd0);

        // Single register write with the consumer ready
        do_reset();
        trc_ready = 1'b1;
        retire(16'h0004, 1'b1, 4'd3, 16'h0042, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        idle();
        check("rw_valid", 64'(trc_valid), 64'd1);
        check("rw_kind", 64'(trc_kind), 64'd1);
        check("rw_load", 64'(trc_load), 64'd0);
        check("rw_inum", 64'(trc_inum), 64'd0);
        check("rw_pc", 64'(trc_pc), 64'h0004);
        check("rw_reg", 64'(trc_reg), 64'd3);
        check("rw_value", 64'(trc_value), 64'h0042);
        check("rw_addr", 64'(trc_addr), 64'd0);
        check("rw_inst", 64'(inst_cnt), 64'd1);
        tick();
        check("rw_popped", 64'(trc_valid), 64'd0);

        // Load followed by store, queued then drained
        do_reset();
        retire(16'h0008, 1'b1, 4'd5, 16'h1234, 1'b1, 1'b0, 16'h00A0, 16'h0, 1'b0);
        tick();
        retire(16'h000A, 1'b0, 4'd0, 16'h0, 1'b0, 1'b1, 16'h00A2, 16'hBEEF, 1'b0);
        tick();
        idle();
        check("ld_kind", 64'(trc_kind), 64'd1);
        check("ld_load", 64'(trc_load), 64'd1);
        check("ld_reg", 64'(trc_reg), 64'd5);
        check("ld_value", 64'(trc_value), 64'h1234);
        check("ld_addr", 64'(trc_addr), 64'h00A0);
        check("ld_inum", 64'(trc_inum), 64'd0);
        trc_ready = 1'b1;
        tick();
        check("st_kind", 64'(trc_kind), 64'd2);
        check("st_load", 64'(trc_load), 64'd0);
        check("st_reg", 64'(trc_reg), 64'd0);
        check("st_value", 64'(trc_value), 64'hBEEF);
        check("st_addr", 64'(trc_addr), 64'h00A2);
        check("st_inum", 64'(trc_inum), 64'd1);
        check("st_pc", 64'(trc_pc), 64'h000A);
        tick();
        check("ldst_empty", 64'(trc_valid), 64'd0);

        // Overflow drops, reserved halt slot, drain to DONE
        do_reset();
        for (int i = 0; i < 5; i++) begin
            retire(16'h0200 + 16'(2 * i), 1'b1, 4'(i + 1), 16'h0A00 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            tick();
        end
        check("ovf_drop", 64'(drop_cnt), 64'd2);
        check("ovf_inst", 64'(inst_cnt), 64'd5);
        check("ovf_halted_pre", 64'(halted), 64'd0);
        retire(16'h020A, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        idle();
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_inst", 64'(inst_cnt), 64'd6);
        check("halt_drop", 64'(drop_cnt), 64'd2);
        check("halt_cycle", 64'(cycle_cnt), 64'd6);
        tick();
        retire(16'h0300, 1'b1, 4'd7, 16'h7777, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        idle();
        check("drain_ignored_inst", 64'(inst_cnt), 64'd6);
        check("drain_cycle_frozen", 64'(cycle_cnt), 64'd6);
        check("drain_head_inum", 64'(trc_inum), 64'd0);
        check("drain_head_value", 64'(trc_value), 64'h0A00);
        trc_ready = 1'b1;
        tick();
        check("pop1_inum", 64'(trc_inum), 64'd1);
        tick();
        check("pop2_inum", 64'(trc_inum), 64'd2);
        check("pop2_pc", 64'(trc_pc), 64'h0204);
        tick();
        check("halt_rec_kind", 64'(trc_kind), 64'd3);
        check("halt_rec_inum", 64'(trc_inum), 64'd5);
        check("halt_rec_pc", 64'(trc_pc), 64'h020A);
        check("halt_rec_value", 64'(trc_value), 64'd0);
        check("done_before_pop", 64'(done), 64'd0);
        tick();
        check("done_after_pop", 64'(done), 64'd1);
        check("done_empty", 64'(trc_valid), 64'd0);
        check("done_cycle", 64'(cycle_cnt), 64'd6);
        check("done_timeout", 64'(timeout), 64'd0);

        // Pre-pop occupancy rule: push at count DEPTH-1 with a simultaneous pop is dropped
        do_reset();
        for (int i = 0; i < 3; i++) begin
            retire(16'h0400 + 16'(i), 1'b1, 4'd2, 16'h0B00 + 16'(i), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
            tick();
        end
        retire(16'h0403, 1'b1, 4'd2, 16'h0BFF, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        trc_ready = 1'b1;
        tick();
        idle();
        check("pp_drop", 64'(drop_cnt), 64'd1);
        check("pp_inst", 64'(inst_cnt), 64'd4);
        check("pp_head1", 64'(trc_inum), 64'd1);
        tick();
        check("pp_head2", 64'(trc_inum), 64'd2);
        check("pp_head2_valid", 64'(trc_valid), 64'd1);
        tick();
        check("pp_empty", 64'(trc_valid), 64'd0);

        // Watchdog: one retirement, then sixteen idle RUN cycles
        do_reset();
        trc_ready = 1'b1;
        retire(16'h0500, 1'b1, 4'd4, 16'h0C00, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        idle();
        repeat (15) tick();
        check("wd_idle15", 64'(timeout), 64'd0);
        tick();
        check("wd_idle16", 64'(timeout), 64'd1);
        retire(16'h0502, 1'b1, 4'd4, 16'h0C01, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        tick();
        idle();
        check("wd_ignored_inst", 64'(inst_cnt), 64'd1);
        check("wd_ignored_halt", 64'(halted), 64'd0);
        check("wd_sticky", 64'(timeout), 64'd1);
        check("wd_no_done", 64'(done), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/retire_trace_unit.md
Name: retire_trace_unit

Overview:
- Synthesizable retirement monitor that sits beside the cpu writeback stage.
- Each cycle it classifies the retired instruction (register write, load, store, halt or other) and pushes a trace record into an internal FIFO. Records are drained over a valid/ready port.
- Maintains cycle, retired-instruction and dropped-record counters, plus a hang watchdog and halt/done tracking, so runs are observable on silicon/FPGA without a simulator file dump.

Parameters:
DATA_W, 16, width of register write data and memory data
ADDR_W, 16, width of PC and memory address
REG_W, 4, register index width
CNT_W, 32, width of cycle/inst/drop counters
DEPTH, 8, trace FIFO entries (power of two, >=2)
WDOG_LIMIT, 100000, consecutive cycles without retirement before timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ret_valid  in  1  an instruction retires this cycle
ret_pc  in  ADDR_W  PC of retiring instruction
ret_regwrite  in  1  retiring instruction writes register file
ret_wreg  in  REG_W  destination register
ret_wdata  in  DATA_W  register write data
ret_memread  in  1  retiring instruction is a load
ret_memwrite  in  1  retiring instruction is a store
ret_memaddr  in  ADDR_W  memory address
ret_memdata  in  DATA_W  store data
ret_halt  in  1  retiring instruction is halt
trc_valid  out  1  head record available
trc_ready  in  1  consumer accepts head record
trc_kind  out  2  00 other, 01 reg write, 10 store, 11 halt
trc_load  out  1  reg-write record came from a load
trc_inum  out  CNT_W  0-based instruction number
trc_pc  out  ADDR_W  record PC
trc_reg  out  REG_W  destination register (0 if not kind 01)
trc_value  out  DATA_W  wdata (kind 01), memdata (kind 10), else 0
trc_addr  out  ADDR_W  memaddr for loads/stores, else 0
cycle_cnt  out  CNT_W  cycles spent in RUN
inst_cnt  out  CNT_W  retirements accepted
drop_cnt  out  CNT_W  records dropped due to FIFO full (saturating)
halted  out  1  halt has retired
done  out  1  halt record consumed, FIFO empty
timeout  out  1  watchdog expired (sticky)

Behaviour:
- Async reset: all counters 0, FIFO empty, trc_valid=0, halted=done=timeout=0, state RUN. Reset mid-run discards FIFO contents.
- States:
  - RUN -> DRAIN when ret_valid & ret_halt.
  - DRAIN -> DONE when the halt record pops (trc_valid & trc_ready on a kind-11 head).
  - RUN -> TIMEOUT on watchdog expiry.
  - DONE and TIMEOUT are terminal until reset.
- ret_* inputs are sampled only in RUN; ignored in DRAIN/DONE/TIMEOUT.
- cycle_cnt increments every RUN cycle, including the halt cycle; frozen otherwise. All counters wrap at 2^CNT_W except drop_cnt.
- Classification priority: halt > regwrite > memwrite > other. trc_load = ret_memread & ret_regwrite. trc_addr is valid when memread or memwrite, else 0.
- Each accepted ret_valid produces trc_inum = inst_cnt before increment, then inst_cnt+1.
- FIFO occupancy is evaluated at the start of the cycle (pre-pop count):
  - Non-halt records push only when count < DEPTH-1. Otherwise the record is dropped, drop_cnt+1, and inst_cnt still increments.
  - The halt record pushes when count < DEPTH. The last slot is reserved for halt, so halt is never dropped.
- Push and pop in the same cycle are both legal; count stays unchanged.
- Latency: a record pushed at edge N is visible with trc_valid=1 after edge N (one cycle after ret_valid sampled). trc_* present the head entry; trc_valid = (count != 0). Head is stable while trc_valid & !trc_ready.
- halted=1 from the edge that accepts the halt. done=1 on entry to DONE.
- Watchdog:
  - Counter clears on every accepted ret_valid and increments each RUN cycle without ret_valid.
  - On the edge where it would reach WDOG_LIMIT: state -> TIMEOUT, timeout=1, cycle_cnt stops.
  - The FIFO keeps draining in TIMEOUT. A halt in the same cycle as expiry wins (goes to DRAIN).

Test Plan:
1. rst_n low mid-run with 3 records queued -> trc_valid=0, cycle_cnt=inst_cnt=drop_cnt=0, halted=done=timeout=0 immediately (async).
2. ret_valid, regwrite, pc=0x0004, wreg=3, wdata=0x0042, trc_ready=1 -> next cycle trc_valid=1, kind=01, load=0, inum=0, reg=3, value=0x0042, addr=0; inst_cnt=1.
3. Load pc=0x0008, wreg=5, wdata=0x1234, memaddr=0x00A0, then store pc=0x000A, addr=0x00A2, data=0xBEEF -> kind 01 load=1 addr=0x00A0; kind 10 value=0xBEEF addr=0x00A2; inum 0,1.
4. DEPTH=4, trc_ready=0, 5 back-to-back reg writes then halt -> 3 queued, drop_cnt=2, inst_cnt=6 after halt, halt queued at count 3->4, halted=1; then trc_ready=1 -> 4 pops, done=1 after the halt pop, cycle_cnt frozen at 6.
5. WDOG_LIMIT=16, one retirement then 16 idle cycles -> timeout=1 exactly at the 16th idle edge, state TIMEOUT; later ret_valid ignored (inst_cnt stays 1).
6. FIFO at count=DEPTH-1 with simultaneous pop and non-halt push -> record dropped (pre-pop rule), count becomes DEPTH-2, drop_cnt+1.
